// File: rtl/uart_cmd_master.sv
// uart_cmd_master: sends one command byte through uart_top and waits for the ACK byte,
// with response timeout, bounded retry and a per-command status report.
module uart_cmd_master #(
   parameter int         TIMEOUT_CYCLES = 500_000,
   parameter int         MAX_RETRIES    = 2,
   parameter logic [7:0] ACK_BYTE       = 8'hAA
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cmd_valid,
   input  logic [7:0] i_cmd_byte,
   output logic       o_cmd_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic [1:0] o_status,
   output logic [7:0] o_resp_byte,
   output logic [3:0] o_attempts,
   output logic       o_tx_dv,
   output logic [7:0] o_tx_byte,
   input  logic       i_tx_active,
   input  logic       i_tx_done,
   input  logic       i_rx_dv,
   input  logic [7:0] i_rx_byte
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_FINISH} state_t;
   state_t        r_state, w_next;
   logic [CW-1:0] r_tmo;
   logic [3:0]    r_retry, r_attempts;
   logic [7:0]    r_cmd, r_resp;
   logic [1:0]    r_status, w_result;
   logic          w_ok, w_tmo, w_fail, w_can_retry, w_wait_ack;
   assign w_wait_ack  = r_state == S_WAIT_ACK;
   assign w_ok        = i_rx_dv && i_rx_byte == ACK_BYTE;
   assign w_tmo       = r_tmo == CW'(TIMEOUT_CYCLES - 1);
   // a received byte takes priority over a timeout in the same cycle
   assign w_fail      = !w_ok && (i_rx_dv || w_tmo);
   assign w_result    = w_ok ? 2'b00 : i_rx_dv ? 2'b10 : 2'b01;
   assign w_can_retry = r_retry < 4'(MAX_RETRIES);
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = i_cmd_valid ? S_SEND : S_IDLE;
         S_SEND:     w_next = i_tx_active ? S_SEND : S_WAIT_TX;
         S_WAIT_TX:  w_next = i_tx_done ? S_WAIT_ACK : S_WAIT_TX;
         S_WAIT_ACK: w_next = w_ok ? S_FINISH : !w_fail ? S_WAIT_ACK : w_can_retry ? S_SEND : S_FINISH;
         default:    w_next = S_IDLE;
      endcase
   end
   always_comb begin
      o_cmd_ready = r_state == S_IDLE;
      o_busy      = r_state != S_IDLE;
      o_done      = r_state == S_FINISH;
      o_tx_dv     = r_state == S_SEND && !i_tx_active;
   end
   assign o_tx_byte   = r_cmd;
   assign o_status    = r_status;
   assign o_resp_byte = r_resp;
   assign o_attempts  = r_attempts;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cmd      <= '0;
         r_retry    <= '0;
         r_attempts <= '0;
         r_tmo      <= '0;
         r_resp     <= '0;
         r_status   <= '0;
      end else begin
         if (o_cmd_ready && i_cmd_valid) begin
            r_cmd      <= i_cmd_byte;
            r_retry    <= '0;
            r_attempts <= '0;
         end
         if (o_tx_dv && r_attempts != 4'hF) r_attempts <= r_attempts + 4'd1;
         r_tmo <= w_wait_ack ? r_tmo + CW'(1) : '0;
         if (w_wait_ack && i_rx_dv) r_resp <= i_rx_byte;
         if (w_wait_ack && w_fail && w_can_retry) r_retry <= r_retry + 4'd1;
         if (w_wait_ack && w_next == S_FINISH) r_status <= w_result;
      end
   end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: directed stimulus with a queue-based scoreboard; a negedge monitor
// checks every o_tx_dv and o_done against expectations pushed by the stimulus.
module tb_uart_cmd_master;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   logic       cmd_valid = 0, tx_active = 0, tx_done = 0, rx_dv = 0;
   logic [7:0] cmd_byte = 0, rx_byte = 0;
   logic       cmd_ready, busy, done, tx_dv;
   logic [1:0] status;
   logic [7:0] resp, tx_byte;
   logic [3:0] attempts;
   logic       b_cmd_valid = 0, b_tx_done = 0, b_rx_dv = 0;
   logic [7:0] b_cmd_byte = 0, b_rx_byte = 0;
   logic       b_ready, b_busy, b_done, b_tx_dv;
   logic [1:0] b_status;
   logic [7:0] b_resp, b_tx_byte;
   logic [3:0] b_attempts;

   uart_cmd_master #(.TIMEOUT_CYCLES(100), .MAX_RETRIES(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd_byte(cmd_byte),
      .o_cmd_ready(cmd_ready), .o_busy(busy), .o_done(done), .o_status(status),
      .o_resp_byte(resp), .o_attempts(attempts), .o_tx_dv(tx_dv), .o_tx_byte(tx_byte),
      .i_tx_active(tx_active), .i_tx_done(tx_done), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte));

   uart_cmd_master #(.TIMEOUT_CYCLES(100), .MAX_RETRIES(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(b_cmd_valid), .i_cmd_byte(b_cmd_byte),
      .o_cmd_ready(b_ready), .o_busy(b_busy), .o_done(b_done), .o_status(b_status),
      .o_resp_byte(b_resp), .o_attempts(b_attempts), .o_tx_dv(b_tx_dv), .o_tx_byte(b_tx_byte),
      .i_tx_active(1'b0), .i_tx_done(b_tx_done), .i_rx_dv(b_rx_dv), .i_rx_byte(b_rx_byte));

   typedef struct {logic [1:0] st; logic [7:0] rb; logic [3:0] at;} exp_t;
   exp_t q[$], q0[$];
   int   txq[$], gapq[$];
   int   checks = 0, passes = 0;
   int   cyc = 0, t_done = 0, b_tx_cnt = 0, g;
   exp_t e;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(posedge clk) cyc++;

   // monitor: compares DUT-presented transactions against the scoreboard queues
   always @(negedge clk) begin
      if (tx_done) t_done = cyc;
      if (tx_dv) begin
         if (txq.size() == 0) chk("tx_dv unexpected", tx_dv, 0);
         else begin
            chk("tx_byte", tx_byte, txq.pop_front());
            g = gapq.pop_front();
            if (g >= 0) chk("tx_done->resend gap", cyc - t_done, g);
         end
      end
      if (done) begin
         if (q.size() == 0) chk("done unexpected", done, 0);
         else begin
            e = q.pop_front();
            chk("status", status, e.st);
            chk("resp_byte", resp, e.rb);
            chk("attempts", attempts, e.at);
         end
      end
      if (b_tx_dv) b_tx_cnt++;
      if (b_done) begin
         if (q0.size() == 0) chk("dut0 done unexpected", b_done, 0);
         else begin
            e = q0.pop_front();
            chk("dut0 status", b_status, e.st);
            chk("dut0 resp_byte", b_resp, e.rb);
            chk("dut0 attempts", b_attempts, e.at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cmd(input logic [1:0] st, input logic [7:0] rb, input logic [3:0] at);
      exp_t x;
      x.st = st; x.rb = rb; x.at = at;
      q.push_back(x);
   endtask

   task automatic expect_tx(input int b, input int gap);
      txq.push_back(b);
      gapq.push_back(gap);
   endtask

   task automatic issue(input logic [7:0] b);
      cmd_valid = 1; cmd_byte = b;
      tick();
      cmd_valid = 0;
   endtask

   task automatic wait_txdv(input string n);
      for (int i = 0; i < 300 && !tx_dv; i++) tick();
      if (!tx_dv) chk({n, " tx_dv wait expired"}, tx_dv, 1);
   endtask

   // consume the tx_dv cycle and emulate uart_top transmitting the byte
   task automatic do_tx();
      tick();
      tx_active = 1;
      repeat (3) tick();
      tx_done = 1; tx_active = 0;
      tick();
      tx_done = 0;
   endtask

   task automatic respond(input int dly, input logic [7:0] b);
      repeat (dly) tick();
      rx_dv = 1; rx_byte = b;
      tick();
      rx_dv = 0;
   endtask

   task automatic wait_idle(input string n);
      for (int i = 0; i < 400 && !cmd_ready; i++) tick();
      chk({n, " back to idle"}, cmd_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) tick();
      chk("rst cmd_ready", cmd_ready, 1);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst status", status, 0);
      chk("rst resp_byte", resp, 0);
      chk("rst attempts", attempts, 0);
      chk("rst tx_dv", tx_dv, 0);
      chk("rst tx_byte", tx_byte, 0);
      rst_n = 1;
      tick();
      // timeout with two retries: resend 101 cycles after each tx_done, resp untouched
      expect_tx(8'h01, -1); expect_tx(8'h01, 101); expect_tx(8'h01, 101);
      expect_cmd(2'b01, 8'h00, 4'd3);
      issue(8'h01);
      for (int a = 0; a < 3; a++) begin
         wait_txdv("timeout");
         do_tx();
      end
      wait_idle("timeout");
      // ack path
      expect_tx(8'h03, -1);
      expect_cmd(2'b00, 8'hAA, 4'd1);
      issue(8'h03);
      chk("accept->tx_dv latency", tx_dv, 1);
      wait_txdv("ack");
      do_tx();
      respond(19, 8'hAA);
      chk("ack->done latency", done, 1);
      wait_idle("ack");
      // bad response then good: resend 11 cycles after tx_done
      expect_tx(8'h02, -1); expect_tx(8'h02, 11);
      expect_cmd(2'b00, 8'hAA, 4'd2);
      issue(8'h02);
      wait_txdv("bad1");
      do_tx();
      respond(9, 8'h55);
      wait_txdv("bad2");
      do_tx();
      respond(5, 8'hAA);
      wait_idle("bad-good");
      // ACK on the exact timeout cycle wins, no resend
      expect_tx(8'h04, -1);
      expect_cmd(2'b00, 8'hAA, 4'd1);
      issue(8'h04);
      wait_txdv("collide");
      do_tx();
      respond(99, 8'hAA);
      wait_idle("collide");
      repeat (120) tick();
      // flow control, busy command rejection and stray bytes
      tx_active = 1;
      rx_dv = 1; rx_byte = 8'h77;
      tick();
      rx_dv = 0;
      chk("stray rx in idle", resp, 8'hAA);
      expect_tx(8'h05, -1);
      expect_cmd(2'b00, 8'hAA, 4'd1);
      cmd_valid = 1; cmd_byte = 8'h05;
      tick();
      cmd_byte = 8'h99;
      for (int i = 0; i < 4; i++) begin
         chk("tx_dv held off by tx_active", tx_dv, 0);
         chk("cmd_ready while busy", cmd_ready, 0);
         tick();
      end
      cmd_valid = 0; tx_active = 0;
      #1;
      chk("tx_dv after tx_active falls", tx_dv, 1);
      tick();
      rx_dv = 1; rx_byte = 8'h77;
      tick();
      rx_dv = 0; tx_active = 1;
      tick();
      tx_done = 1; tx_active = 0;
      tick();
      tx_done = 0;
      chk("stray rx in wait_tx", resp, 8'hAA);
      respond(10, 8'hAA);
      wait_idle("flow");
      // reset in WAIT_ACK: no done, outputs cleared, late ACK ignored
      expect_tx(8'h07, -1);
      issue(8'h07);
      wait_txdv("mid-reset");
      do_tx();
      repeat (10) tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      chk("mid-reset cmd_ready", cmd_ready, 1);
      chk("mid-reset status", status, 0);
      chk("mid-reset attempts", attempts, 0);
      chk("mid-reset resp_byte", resp, 0);
      chk("mid-reset tx_dv", tx_dv, 0);
      respond(5, 8'hAA);
      chk("late ack ignored", resp, 0);
      repeat (150) tick();
      // MAX_RETRIES=0: bad byte on the timeout cycle reports BAD_RESP
      begin
         exp_t x;
         x.st = 2'b10; x.rb = 8'h55; x.at = 4'd1;
         q0.push_back(x);
      end
      b_cmd_valid = 1; b_cmd_byte = 8'h09;
      tick();
      b_cmd_valid = 0;
      chk("dut0 tx_dv", b_tx_dv, 1);
      chk("dut0 tx_byte", b_tx_byte, 8'h09);
      tick();
      b_tx_done = 1;
      tick();
      b_tx_done = 0;
      repeat (99) tick();
      b_rx_dv = 1; b_rx_byte = 8'h55;
      tick();
      b_rx_dv = 0;
      chk("dut0 done on collision", b_done, 1);
      repeat (150) tick();
      chk("dut0 single send", b_tx_cnt, 1);
      chk("dut0 idle", b_ready, 1);
      chk("pending done entries", q.size(), 0);
      chk("pending tx entries", txq.size(), 0);
      chk("dut0 pending done entries", q0.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
